video_pattern_gen: RTL and testbench



---
 rtl/video_pkg.sv | 39 +++
 rtl/video_timing_core.sv | 61 ++++++
 rtl/video_pattern_gen.sv | 191 +++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video test-pattern generator.
//   - default 640x480@60 timing constants
//   - pattern mode encoding
//   - 8-entry colour-bar table as {r,g,b} channel enables
package video_pkg;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FRONT   = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BACK    = 48;
   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FRONT   = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BACK    = 33;

   typedef enum logic [1:0] {
      PAT_BARS   = 2'd0,
      PAT_CHECK  = 2'd1,
      PAT_RAMP   = 2'd2,
      PAT_SCROLL = 2'd3
   } pattern_e;

   // white, yellow, cyan, green, magenta, red, blue, black
   function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
      logic [2:0] rgb;
      case (idx)
         3'd0:    rgb = 3'b111;
         3'd1:    rgb = 3'b110;
         3'd2:    rgb = 3'b011;
         3'd3:    rgb = 3'b010;
         3'd4:    rgb = 3'b101;
         3'd5:    rgb = 3'b100;
         3'd6:    rgb = 3'b001;
         default: rgb = 3'b000;
      endcase
      return rgb;
   endfunction

endpackage

// File: rtl/video_timing_core.sv
// Raster counters and unregistered sync/active decode.
// Ports:
//   clk_pixel, rst      pixel clock, synchronous active-high reset
//   hcount, vcount      current raster position
//   hsync, vsync        sync levels at the configured polarity
//   active              position is inside the visible area
//   line_wrap           last pixel of a line (hcount wraps next)
//   frame_wrap          last pixel of the frame (both counters wrap next)
module video_timing_core
   import video_pkg::*;
#(
   parameter int H_VISIBLE = VGA_H_VISIBLE,
   parameter int H_FRONT   = VGA_H_FRONT,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BACK    = VGA_H_BACK,
   parameter int V_VISIBLE = VGA_V_VISIBLE,
   parameter int V_FRONT   = VGA_V_FRONT,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BACK    = VGA_V_BACK,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
   localparam int HW       = $clog2(H_TOTAL + 1),
   localparam int VW       = $clog2(V_TOTAL + 1)
)(
   input  logic          clk_pixel,
   input  logic          rst,
   output logic [HW-1:0] hcount,
   output logic [VW-1:0] vcount,
   output logic          hsync,
   output logic          vsync,
   output logic          active,
   output logic          line_wrap,
   output logic          frame_wrap
);

   assign line_wrap  = (hcount == HW'(H_TOTAL - 1));
   assign frame_wrap = line_wrap && (vcount == VW'(V_TOTAL - 1));

   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         hcount <= '0;
         vcount <= '0;
      end else if (line_wrap) begin
         hcount <= '0;
         vcount <= frame_wrap ? '0 : vcount + VW'(1);
      end else begin
         hcount <= hcount + HW'(1);
      end
   end

   always_comb begin
      hsync  = ((hcount >= HW'(H_VISIBLE + H_FRONT)) &&
                (hcount <  HW'(H_VISIBLE + H_FRONT + H_SYNC))) ? HSYNC_POL : ~HSYNC_POL;
      vsync  = ((vcount >= VW'(V_VISIBLE + V_FRONT)) &&
                (vcount <  VW'(V_VISIBLE + V_FRONT + V_SYNC))) ? VSYNC_POL : ~VSYNC_POL;
      active = (hcount < HW'(H_VISIBLE)) && (vcount < VW'(V_VISIBLE));
   end

endmodule

// File: rtl/video_pattern_gen.sv
// Parametrised VGA/DVI timing and test-pattern source.
// Ports:
//   clk_pixel, rst            pixel clock, synchronous active-high reset
//   mode                      pattern select, taken at frame boundaries
//   hsync, vsync              sync outputs
//   video_active              visible pixel
//   red, green, blue          pixel colour (zero outside visible area)
//   frame_start               one-cycle pulse with pixel (0,0)
//   frame_count               completed-frame counter, wraps at 256
// All outputs come from one register stage fed by the current counter state.
module video_pattern_gen
   import video_pkg::*;
#(
   parameter int H_VISIBLE  = VGA_H_VISIBLE,
   parameter int H_FRONT    = VGA_H_FRONT,
   parameter int H_SYNC     = VGA_H_SYNC,
   parameter int H_BACK     = VGA_H_BACK,
   parameter int V_VISIBLE  = VGA_V_VISIBLE,
   parameter int V_FRONT    = VGA_V_FRONT,
   parameter int V_SYNC     = VGA_V_SYNC,
   parameter int V_BACK     = VGA_V_BACK,
   parameter bit HSYNC_POL  = 1'b0,
   parameter bit VSYNC_POL  = 1'b0,
   parameter int COLOR_W    = 2,
   parameter int CHECK_LOG2 = 5
)(
   input  logic               clk_pixel,
   input  logic               rst,
   input  logic [1:0]         mode,
   output logic               hsync,
   output logic               vsync,
   output logic               video_active,
   output logic [COLOR_W-1:0] red,
   output logic [COLOR_W-1:0] green,
   output logic [COLOR_W-1:0] blue,
   output logic               frame_start,
   output logic [7:0]         frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int BAR_W   = H_VISIBLE / 8;
   localparam int STEP    = H_VISIBLE >> COLOR_W;
   localparam logic [COLOR_W-1:0] MAX = '1;

   logic [HW-1:0] hcount;
   logic [VW-1:0] vcount;
   logic          hsync_c, vsync_c, active_c, line_wrap, frame_wrap;

   video_timing_core #(
      .H_VISIBLE (H_VISIBLE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
      .V_VISIBLE (V_VISIBLE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK),
      .HSYNC_POL (HSYNC_POL), .VSYNC_POL (VSYNC_POL)
   ) u_core (
      .clk_pixel  (clk_pixel),
      .rst        (rst),
      .hcount     (hcount),
      .vcount     (vcount),
      .hsync      (hsync_c),
      .vsync      (vsync_c),
      .active     (active_c),
      .line_wrap  (line_wrap),
      .frame_wrap (frame_wrap)
   );

   pattern_e mode_q;
   logic [7:0] fc_q;

   always_ff @(posedge clk_pixel) begin
      if (rst || frame_wrap) mode_q <= pattern_e'(mode);
      if (rst)               fc_q   <= '0;
      else if (frame_wrap)   fc_q   <= fc_q + 8'd1;
   end

   // Per-pixel division by BAR_W / STEP is done with running counters that
   // restart on every line. The scroll counter restarts at the frame's offset
   // (frame_count mod H_VISIBLE), tracked as a bar index plus position within
   // the bar; the 3-bit bar index wraps exactly at H_VISIBLE.
   logic [2:0]         bar_idx, sbar, start_bar, start_bar_nx;
   logic [HW-1:0]      bar_sub, ssub, start_sub, start_sub_nx, ramp_sub;
   logic [COLOR_W-1:0] ramp_idx;

   always_comb begin
      start_bar_nx = start_bar;
      start_sub_nx = start_sub;
      if (frame_wrap) begin
         if (fc_q == 8'hff) begin
            start_bar_nx = '0;
            start_sub_nx = '0;
         end else if (start_sub == HW'(BAR_W - 1)) begin
            start_bar_nx = start_bar + 3'd1;
            start_sub_nx = '0;
         end else begin
            start_sub_nx = start_sub + HW'(1);
         end
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         start_bar <= '0;
         start_sub <= '0;
      end else begin
         start_bar <= start_bar_nx;
         start_sub <= start_sub_nx;
      end

      if (rst || line_wrap) begin
         bar_idx  <= '0;
         bar_sub  <= '0;
         ramp_idx <= '0;
         ramp_sub <= '0;
         sbar     <= rst ? 3'd0 : start_bar_nx;
         ssub     <= rst ? '0   : start_sub_nx;
      end else begin
         if (bar_sub == HW'(BAR_W - 1)) begin
            bar_sub <= '0;
            bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_sub <= bar_sub + HW'(1);
         end
         if (ssub == HW'(BAR_W - 1)) begin
            ssub <= '0;
            sbar <= sbar + 3'd1;
         end else begin
            ssub <= ssub + HW'(1);
         end
         if (ramp_sub == HW'(STEP - 1)) begin
            ramp_sub <= '0;
            if (ramp_idx != MAX) ramp_idx <= ramp_idx + COLOR_W'(1);
         end else begin
            ramp_sub <= ramp_sub + HW'(1);
         end
      end
   end

   logic               cx, cy;
   logic [2:0]         en;
   logic [COLOR_W-1:0] red_d, green_d, blue_d;

   assign cx = ((hcount >> CHECK_LOG2) & HW'(1)) != '0;
   assign cy = ((vcount >> CHECK_LOG2) & VW'(1)) != '0;

   always_comb begin
      en      = 3'b000;
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      if (active_c) begin
         case (mode_q)
            PAT_BARS:   en = bar_rgb(bar_idx);
            PAT_CHECK:  en = (cx ^ cy) ? 3'b111 : 3'b000;
            PAT_SCROLL: en = bar_rgb(sbar);
            default:    en = 3'b000;
         endcase
         red_d   = en[2] ? MAX : '0;
         green_d = en[1] ? MAX : '0;
         blue_d  = en[0] ? MAX : '0;
         if (mode_q == PAT_RAMP) begin
            red_d   = ramp_idx;
            green_d = ramp_idx;
            blue_d  = ramp_idx;
         end
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         hsync        <= ~HSYNC_POL;
         vsync        <= ~VSYNC_POL;
         video_active <= 1'b0;
         red          <= '0;
         green        <= '0;
         blue         <= '0;
         frame_start  <= 1'b0;
         frame_count  <= '0;
      end else begin
         hsync        <= hsync_c;
         vsync        <= vsync_c;
         video_active <= active_c;
         red          <= red_d;
         green        <= green_d;
         blue         <= blue_d;
         frame_start  <= (hcount == '0) && (vcount == '0);
         frame_count  <= fc_q;
      end
   end

endmodule

// File: tb/tb_video_pattern_gen.sv
module tb_video_pattern_gen;

   localparam int HV = 32, HF = 2, HS = 3, HB = 3;
   localparam int VV = 4,  VF = 1, VS = 1, VB = 1;
   localparam int CW = 2, CL = 1;
   localparam bit HPOL = 1'b1, VPOL = 1'b0;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FR = HT * VT;
   localparam int BARW = HV / 8;
   localparam int STEP = HV >> CW;
   localparam int MAXC = (1 << CW) - 1;
   localparam logic [17:0] RESET_VEC = {!HPOL, !VPOL, 16'd0};
   localparam logic [2:0] BAR_TAB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                          3'b101, 3'b100, 3'b001, 3'b000};

   logic clk_pixel = 1'b0;
   always #5 clk_pixel = ~clk_pixel;

   logic          rst;
   logic [1:0]    mode;
   logic          hsync, vsync, video_active, frame_start;
   logic [CW-1:0] red, green, blue;
   logic [7:0]    frame_count;
   logic [17:0]   out_vec;
   logic [5:0]    rgb;

   assign out_vec = {hsync, vsync, video_active, red, green, blue, frame_start, frame_count};
   assign rgb     = {red, green, blue};

   video_pattern_gen #(
      .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
      .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
      .HSYNC_POL (HPOL), .VSYNC_POL (VPOL), .COLOR_W (CW), .CHECK_LOG2 (CL)
   ) dut (
      .clk_pixel    (clk_pixel),
      .rst          (rst),
      .mode         (mode),
      .hsync        (hsync),
      .vsync        (vsync),
      .video_active (video_active),
      .red          (red),
      .green        (green),
      .blue         (blue),
      .frame_start  (frame_start),
      .frame_count  (frame_count)
   );

   int          n_checks = 0;
   int          n_pass = 0;
   int          p = -1;
   logic [1:0]  model_mode = 2'd0;
   logic [1:0]  next_mode = 2'd0;
   logic [17:0] exp_vec = RESET_VEC;

   // Expected outputs for the p-th pixel since reset release, from raster
   // arithmetic on the absolute pixel index.
   function automatic logic [17:0] model(input int pp, input logic [1:0] m);
      int h, v, fc, x, r, g, b;
      logic [2:0] en;
      logic hs, vs, act, fs;
      h  = pp % HT;
      v  = (pp / HT) % VT;
      fc = (pp / FR) % 256;
      hs = (h >= HV + HF && h < HV + HF + HS) ? HPOL : !HPOL;
      vs = (v >= VV + VF && v < VV + VF + VS) ? VPOL : !VPOL;
      act = (h < HV) && (v < VV);
      fs = (h == 0) && (v == 0);
      r = 0; g = 0; b = 0; en = 3'b000;
      if (act) begin
         case (m)
            2'd0: en = BAR_TAB[h / BARW];
            2'd1: en = ((((h >> CL) ^ (v >> CL)) & 1) == 1) ? 3'b111 : 3'b000;
            2'd3: begin
               x  = (h + fc) % HV;
               en = BAR_TAB[x / BARW];
            end
            default: en = 3'b000;
         endcase
         r = en[2] ? MAXC : 0;
         g = en[1] ? MAXC : 0;
         b = en[0] ? MAXC : 0;
         if (m == 2'd2) begin
            r = h / STEP;
            if (r > MAXC) r = MAXC;
            g = r;
            b = r;
         end
      end
      return {hs, vs, act, 2'(r), 2'(g), 2'(b), fs, 8'(fc)};
   endfunction

   // Advance one clock and update the reference state; no checking here.
   task automatic tick();
      logic [1:0] m_edge;
      logic       r_edge;
      m_edge = mode;
      r_edge = rst;
      @(posedge clk_pixel);
      #1;
      if (r_edge) begin
         p          = -1;
         model_mode = m_edge;
         next_mode  = m_edge;
         exp_vec    = RESET_VEC;
      end else begin
         p = p + 1;
         if (p > 0 && p % FR == 0) model_mode = next_mode;
         exp_vec = model(p, model_mode);
         if (p % FR == FR - 1) next_mode = m_edge;
      end
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      mode = 2'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (out_vec !== RESET_VEC)
            $display("FAIL reset_state cyc=%0d got=%h exp=%h", i, out_vec, RESET_VEC);
         else n_pass++;
      end
      rst = 1'b0;
   endtask

   task automatic test_first_frame();
      int hs_len, hs_first, vs_lines, vs_first, h, v;
      hs_len = 0; hs_first = -1; vs_lines = 0; vs_first = -1;
      for (int i = 0; i < FR; i++) begin
         tick();
         h = p % HT;
         v = (p / HT) % VT;
         n_checks++;
         if (out_vec !== exp_vec)
            $display("FAIL first_frame p=%0d got=%h exp=%h", p, out_vec, exp_vec);
         else n_pass++;
         if (p == 0) begin
            n_checks++;
            if ({frame_start, video_active, rgb} !== 8'b1_1_111111)
               $display("FAIL first_pixel got fs=%b act=%b rgb=%h exp 1 1 3f", frame_start, video_active, rgb);
            else n_pass++;
         end
         if (v == 0 && h == BARW) begin
            n_checks++;
            if (rgb !== 6'b111100) $display("FAIL bar1_yellow got=%h exp=3c", rgb);
            else n_pass++;
         end
         if (v == 0 && h == HV - 1) begin
            n_checks++;
            if (rgb !== 6'b000000) $display("FAIL last_bar_black got=%h exp=00", rgb);
            else n_pass++;
         end
         if (v == 0 && hsync === HPOL) begin
            if (hs_first < 0) hs_first = h;
            hs_len++;
         end
         if (h == 0 && vsync === VPOL) begin
            if (vs_first < 0) vs_first = v;
            vs_lines++;
         end
      end
      n_checks++;
      if (hs_len != HS || hs_first != HV + HF)
         $display("FAIL hsync_pulse got len=%0d start=%0d exp len=%0d start=%0d", hs_len, hs_first, HS, HV + HF);
      else n_pass++;
      n_checks++;
      if (vs_lines != VS || vs_first != VV + VF)
         $display("FAIL vsync_pulse got lines=%0d start=%0d exp lines=%0d start=%0d", vs_lines, vs_first, VS, VV + VF);
      else n_pass++;
   endtask

   task automatic test_mode_switch();
      int f0, q, f;
      mode = 2'd0;
      for (int i = 0; i < FR && (p % FR) != FR - 1; i++) tick();
      f0 = p / FR + 1;
      for (int i = 0; i < 2 * FR; i++) begin
         tick();
         q = p % FR;
         f = p / FR;
         n_checks++;
         if (out_vec !== exp_vec)
            $display("FAIL mode_switch p=%0d got=%h exp=%h", p, out_vec, exp_vec);
         else n_pass++;
         if (f == f0 && q == 3 * HT + BARW) begin
            n_checks++;
            if (rgb !== 6'b111100) $display("FAIL bars_persist got=%h exp=3c", rgb);
            else n_pass++;
         end
         if (f == f0 + 1 && q == 2) begin
            n_checks++;
            if (rgb !== 6'b111111) $display("FAIL check_white got=%h exp=3f", rgb);
            else n_pass++;
         end
         if (f == f0 + 1 && q == 2 * HT + 2) begin
            n_checks++;
            if (rgb !== 6'b000000) $display("FAIL check_black got=%h exp=00", rgb);
            else n_pass++;
         end
         if (f == f0 && q == 2 * HT + 5) mode = 2'd1;
      end
   endtask

   task automatic test_ramp();
      int f0, q;
      mode = 2'd2;
      tick();
      for (int i = 0; i < FR && (p % FR) != FR - 1; i++) tick();
      f0 = p / FR + 1;
      for (int i = 0; i < FR; i++) begin
         tick();
         q = p % FR;
         n_checks++;
         if (out_vec !== exp_vec)
            $display("FAIL ramp p=%0d got=%h exp=%h", p, out_vec, exp_vec);
         else n_pass++;
         if (p / FR == f0 && (q == STEP - 1 || q == STEP || q == HV - 1)) begin
            n_checks++;
            if (q == STEP - 1 && rgb !== 6'b000000)
               $display("FAIL ramp_low got=%h exp=00", rgb);
            else if (q == STEP && rgb !== 6'b010101)
               $display("FAIL ramp_step got=%h exp=15", rgb);
            else if (q == HV - 1 && rgb !== 6'b111111)
               $display("FAIL ramp_top got=%h exp=3f", rgb);
            else n_pass++;
         end
      end
   endtask

   task automatic test_random_modes();
      for (int i = 0; i < 4 * FR; i++) begin
         tick();
         n_checks++;
         if (out_vec !== exp_vec)
            $display("FAIL random_modes p=%0d mode=%0d got=%h exp=%h", p, model_mode, out_vec, exp_vec);
         else n_pass++;
         if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      end
   endtask

   task automatic test_frame_wrap();
      int q;
      mode = 2'd3;
      for (int i = 0; i < 300 * FR && p < 257 * FR; i++) begin
         tick();
         q = p % FR;
         if (q < HT) begin
            n_checks++;
            if (out_vec !== exp_vec)
               $display("FAIL scroll_wrap p=%0d got=%h exp=%h", p, out_vec, exp_vec);
            else n_pass++;
         end
         if (q == 0) begin
            n_checks++;
            if (frame_start !== 1'b1 || frame_count !== 8'((p / FR) % 256))
               $display("FAIL frame_counter p=%0d got fs=%b fc=%0d exp fs=1 fc=%0d",
                        p, frame_start, frame_count, (p / FR) % 256);
            else n_pass++;
         end
         if (p == 256 * FR) begin
            n_checks++;
            if (frame_count !== 8'd0) $display("FAIL fc_rollover got=%0d exp=0", frame_count);
            else n_pass++;
         end
      end
      n_checks++;
      if (p < 257 * FR) $display("FAIL frame_wrap_budget got p=%0d exp>=%0d", p, 257 * FR);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      mode = 2'd3;
      for (int i = 0; i < FR && (p % FR) != 2 * HT + 7; i++) tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if (out_vec !== RESET_VEC)
         $display("FAIL mid_reset got=%h exp=%h", out_vec, RESET_VEC);
      else n_pass++;
      rst = 1'b0;
      for (int i = 0; i < FR + HT; i++) begin
         tick();
         n_checks++;
         if (out_vec !== exp_vec)
            $display("FAIL after_reset p=%0d got=%h exp=%h", p, out_vec, exp_vec);
         else n_pass++;
         if (p == 0) begin
            n_checks++;
            if (frame_start !== 1'b1 || frame_count !== 8'd0 || rgb !== 6'b111111)
               $display("FAIL restart got fs=%b fc=%0d rgb=%h exp fs=1 fc=0 rgb=3f", frame_start, frame_count, rgb);
            else n_pass++;
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      mode = 2'd0;
      test_reset();
      test_first_frame();
      test_mode_switch();
      test_ramp();
      test_random_modes();
      test_frame_wrap();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
